// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// SIPO_PARITY_CHECK_EN adds an even-parity bit to every frame.
package sipo_pkg;

  localparam int WIDTH_D = 4;

  typedef enum logic {
    LSB_FIRST_C = 1'b0,
    MSB_FIRST_C = 1'b1
  } bit_order_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int frame_len(input int w);
`ifdef SIPO_PARITY_CHECK_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  localparam int FRAME_LEN = frame_len(WIDTH_D);

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input side and parallel valid/ready output side of the deserializer.
// SIPO_PARITY_CHECK_EN adds the parity_err signal.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
);
  localparam int CW = clog2(frame_len(WIDTH));

  logic             serial_in;
  logic             bit_valid;
  logic             align;
  logic             out_ready;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;
`ifdef SIPO_PARITY_CHECK_EN
  logic             parity_err;
`endif

  modport master (
    output serial_in, bit_valid, align, out_ready,
`ifdef SIPO_PARITY_CHECK_EN
    input  parity_err,
`endif
    input  parallel_out, out_valid, overrun, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, align, out_ready,
`ifdef SIPO_PARITY_CHECK_EN
    output parity_err,
`endif
    output parallel_out, out_valid, overrun, bit_count
  );

endinterface

// File: rtl/sipo_out_hold.sv
// One-word holding register with valid/ready handoff and overrun pulse.
// SIPO_PARITY_CHECK_EN carries a parity error flag alongside the word.
module sipo_out_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word,
`ifdef SIPO_PARITY_CHECK_EN
  input  logic             par_in,
  output logic             parity_err,
`endif
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic free;

  // A word consumed on the same edge frees the slot for the incoming word.
  assign free = !valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (free) begin
          data  <= word;
          valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
          parity_err <= par_in;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && out_ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Collects a serial bit stream into WIDTH-bit words and hands them off.
// SIPO_PARITY_CHECK_EN: each frame carries a trailing even-parity bit.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_D,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sipo_deserializer_if.slave bus
);

  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);
  localparam int         FL    = frame_len(WIDTH);
  localparam int         CW    = clog2(FL);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             word_done;
`ifdef SIPO_PARITY_CHECK_EN
  logic             par_err;
`endif

  always_comb begin
    shifted   = (ORDER == MSB_FIRST_C) ? {sr[WIDTH-2:0], bus.serial_in}
                                       : {bus.serial_in, sr[WIDTH-1:1]};
    last      = (cnt == CW'(FL - 1));
    word_done = bus.bit_valid && last && !bus.align;
`ifdef SIPO_PARITY_CHECK_EN
    // Last frame bit is parity; the data word is already complete in sr.
    word      = sr;
    par_err   = (^sr) ^ bus.serial_in;
`else
    word      = shifted;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || bus.align) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.bit_valid) begin
      if (last) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= shifted;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.bit_count = cnt;

  sipo_out_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .word_done (word_done),
    .word      (word),
`ifdef SIPO_PARITY_CHECK_EN
    .par_in    (par_err),
    .parity_err(bus.parity_err),
`endif
    .out_ready (bus.out_ready),
    .data      (bus.parallel_out),
    .valid     (bus.out_valid),
    .overrun   (bus.overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
// Under SIPO_PARITY_CHECK_EN every word is sent with its even-parity bit.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic serial_in, bit_valid, align, out_ready;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovr_m = 0;
  int   ovr_l = 0;

  sipo_deserializer_if #(.WIDTH(4)) bm ();
  sipo_deserializer_if #(.WIDTH(4)) bl ();

  assign bm.serial_in = serial_in;
  assign bm.bit_valid = bit_valid;
  assign bm.align     = align;
  assign bm.out_ready = out_ready;
  assign bl.serial_in = serial_in;
  assign bl.bit_valid = bit_valid;
  assign bl.align     = align;
  assign bl.out_ready = out_ready;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bm.overrun) ovr_m++;
    if (bl.overrun) ovr_l++;
  endtask

  task automatic send_raw(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Sends w[3] first; late_ready raises out_ready just before the final frame bit.
  task automatic send_word(input logic [3:0] w, input bit late_ready);
    logic [4:0] fr;
    int n;
`ifdef SIPO_PARITY_CHECK_EN
    fr = {w, ^w};
    n  = 5;
`else
    fr = {1'b0, w};
    n  = 4;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      if (late_ready && i == 0) out_ready = 1'b1;
      serial_in = fr[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; align = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_data",  bm.parallel_out, 4'h0);
    chk("rst_valid", bm.out_valid, 1'b0);
    chk("rst_ovr",   bm.overrun, 1'b0);
    chk("rst_cnt",   bm.bit_count, 0);

    // 1: MSB-first 1010, consumed immediately
    send_word(4'b1010, 1'b0);
    chk("t1_data_m",  bm.parallel_out, 4'b1010);
    chk("t1_valid_m", bm.out_valid, 1'b1);
    chk("t1_data_l",  bl.parallel_out, 4'b0101);
    chk("t1_cnt",     bm.bit_count, 0);
    tick();
    chk("t1_drop",    bm.out_valid, 1'b0);
    chk("t1_hold",    bm.parallel_out, 4'b1010);

    // 2: LSB-first 0101 -> 1010, then F and 0 back to back
    send_word(4'b0101, 1'b0);
    chk("t2_data_l", bl.parallel_out, 4'b1010);
    tick();
    ovr_l = 0;
    send_word(4'b1111, 1'b0);
    chk("t2_w0", bl.parallel_out, 4'hF);
    send_word(4'b0000, 1'b0);
    chk("t2_w1",    bl.parallel_out, 4'h0);
    chk("t2_valid", bl.out_valid, 1'b1);
    chk("t2_ovr",   ovr_l, 0);
    tick();

    // 3: overrun while holding 0011
    out_ready = 1'b0;
    ovr_m = 0;
    send_word(4'b0011, 1'b0);
    send_word(4'b1100, 1'b0);
    chk("t3_ovr_now", bm.overrun, 1'b1);
    chk("t3_data",    bm.parallel_out, 4'b0011);
    chk("t3_valid",   bm.out_valid, 1'b1);
    tick();
    chk("t3_ovr_pulse", bm.overrun, 1'b0);
    chk("t3_ovr_cnt",   ovr_m, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_consume", bm.out_valid, 1'b0);
    send_word(4'b1001, 1'b0);
    chk("t3_next", bm.parallel_out, 4'b1001);
    tick();

    // 4: consume and complete on the same edge
    out_ready = 1'b0;
    send_word(4'b0101, 1'b0);
    chk("t4_held", bm.parallel_out, 4'b0101);
    ovr_m = 0;
    send_word(4'b1111, 1'b1);
    chk("t4_data",  bm.parallel_out, 4'b1111);
    chk("t4_valid", bm.out_valid, 1'b1);
    chk("t4_ovr",   ovr_m, 0);
    tick();

    // 5: reset mid-word, then align mid-word while holding a word
    out_ready = 1'b1;
    send_raw(1'b1);
    send_raw(1'b1);
    chk("t5_cnt2", bm.bit_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", bm.out_valid, 1'b0);
    chk("t5_rst_cnt",   bm.bit_count, 0);
    chk("t5_rst_data",  bm.parallel_out, 4'h0);
    send_word(4'b0110, 1'b0);
    chk("t5_rst_word", bm.parallel_out, 4'b0110);
    tick();
    out_ready = 1'b0;
    send_word(4'b0101, 1'b0);
    send_raw(1'b1);
    send_raw(1'b1);
    align = 1'b1; serial_in = 1'b1; bit_valid = 1'b1; out_ready = 1'b1;
    tick();
    align = 1'b0; bit_valid = 1'b0;
    chk("t5_al_cnt",   bm.bit_count, 0);
    chk("t5_al_hs",    bm.out_valid, 1'b0);
    chk("t5_al_data",  bm.parallel_out, 4'b0101);
    send_word(4'b0110, 1'b0);
    chk("t5_al_word",  bm.parallel_out, 4'b0110);
    chk("t5_al_valid", bm.out_valid, 1'b1);
    tick();

`ifdef SIPO_PARITY_CHECK_EN
    // 6: raw frames with explicit parity bits
    send_raw(1'b1); send_raw(1'b0); send_raw(1'b1); send_raw(1'b0); send_raw(1'b0);
    chk("t6_data0", bm.parallel_out, 4'b1010);
    chk("t6_perr0", bm.parity_err, 1'b0);
    tick();
    send_raw(1'b1); send_raw(1'b0); send_raw(1'b1); send_raw(1'b1); send_raw(1'b0);
    chk("t6_data1", bm.parallel_out, 4'b1011);
    chk("t6_perr1", bm.parity_err, 1'b1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
